// File: rtl/data_generator_pkg.sv
// rtl/data_generator_pkg.sv - shared types and helpers for the multi-channel data generator
package data_generator_pkg;

    typedef enum logic [1:0] {RS_IDLE, RS_FIRST, RS_PAUSE, RS_REPEAT} repeat_state_t;

    localparam int BTN_UP      = 0;
    localparam int BTN_DOWN    = 1;
    localparam int BTN_ZERO    = 2;
    localparam int BTN_SIGN    = 3;
    localparam int BTN_SELECT  = 4;
    localparam int NUM_BUTTONS = 5;

    function automatic int ns_to_cycles(input longint ns, input longint period);
        longint c;
        c = ns / period;
        return (c < 1) ? 1 : int'(c);
    endfunction

    // Result is meaningful in its low 'size' bits (two's complement when signed).
    function automatic logic [31:0] clamp_or_wrap(input int value, input int size,
                                                  input bit is_signed, input bit wrap);
        longint v, lo, hi;
        v = longint'(value);
        if (wrap)
            return 32'(v) & 32'((longint'(1) << size) - 1);
        hi = is_signed ? (longint'(1) << (size - 1)) - 1 : (longint'(1) << size) - 1;
        lo = is_signed ? -(longint'(1) << (size - 1)) : 0;
        if (v > hi)
            v = hi;
        else if (v < lo)
            v = lo;
        return 32'(v);
    endfunction

endpackage

// File: rtl/data_generator_mc_button_conditioner.sv
// rtl/data_generator_mc_button_conditioner.sv - synchroniser, debounce and hold/repeat pulse generator
module button_conditioner
    import data_generator_pkg::*;
#(
    parameter bit Repeat       = 1'b1,
    parameter int FilterCycles = 4,
    parameter int PauseCycles  = 20,
    parameter int RepeatCycles = 10,
    parameter int AccelAfter   = 8
) (
    input  logic Clock,
    input  logic nReset,
    input  logic Button,
    output logic Pulse,
    output logic Fast
);

    localparam int FltW   = $clog2(FilterCycles + 1);
    localparam int TmrMax = (PauseCycles > RepeatCycles) ? PauseCycles : RepeatCycles;
    localparam int TmrW   = $clog2(TmrMax + 1);
    localparam int AccW   = $clog2(AccelAfter + 2);

    logic [1:0]      r_sync;
    logic            r_filt;
    logic [FltW-1:0] r_flt_cnt;
    repeat_state_t   r_state;
    logic [TmrW-1:0] r_tmr;
    logic [AccW-1:0] r_acc;
    logic            r_pulse;
    logic            r_fast;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_sync    <= '0;
            r_filt    <= 1'b0;
            r_flt_cnt <= '0;
        end else begin
            r_sync <= {r_sync[0], Button};
            if (r_sync[1] == r_filt)
                r_flt_cnt <= '0;
            else if (r_flt_cnt == FltW'(FilterCycles - 1)) begin
                r_filt    <= ~r_filt;
                r_flt_cnt <= '0;
            end else
                r_flt_cnt <= r_flt_cnt + FltW'(1);
        end
    end

    // Only pulses issued from REPEAT count towards acceleration.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_state <= RS_IDLE;
            r_tmr   <= '0;
            r_acc   <= '0;
            r_pulse <= 1'b0;
            r_fast  <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            r_fast  <= 1'b0;
            if (!r_filt) begin
                r_state <= RS_IDLE;
                r_tmr   <= '0;
                r_acc   <= '0;
            end else begin
                case (r_state)
                    RS_IDLE: begin
                        r_pulse <= 1'b1;
                        r_tmr   <= '0;
                        r_state <= RS_FIRST;
                    end
                    RS_FIRST: begin
                        r_tmr   <= r_tmr + TmrW'(1);
                        r_state <= RS_PAUSE;
                    end
                    RS_PAUSE: begin
                        if (Repeat) begin
                            if (r_tmr == TmrW'(PauseCycles - 1)) begin
                                r_pulse <= 1'b1;
                                r_tmr   <= '0;
                                r_state <= RS_REPEAT;
                            end else
                                r_tmr <= r_tmr + TmrW'(1);
                        end
                    end
                    RS_REPEAT: begin
                        if (r_tmr == TmrW'(RepeatCycles - 1)) begin
                            r_pulse <= 1'b1;
                            r_fast  <= (r_acc >= AccW'(AccelAfter));
                            r_tmr   <= '0;
                            if (r_acc < AccW'(AccelAfter))
                                r_acc <= r_acc + AccW'(1);
                        end else
                            r_tmr <= r_tmr + TmrW'(1);
                    end
                    default: r_state <= RS_IDLE;
                endcase
            end
        end
    end

    assign Pulse = r_pulse;
    assign Fast  = r_fast;

endmodule

// File: rtl/data_generator_mc.sv
// rtl/data_generator_mc.sv - five-button multi-channel data generator with repeat and acceleration
module data_generator_mc
    import data_generator_pkg::*;
#(
    parameter int    Size               = 4,
    parameter int    Channels           = 4,
    parameter string Signed             = "No",
    parameter string Wrap               = "No",
    parameter int    FastStep           = 4,
    parameter int    AccelAfter         = 8,
    parameter int    ClockPeriod_ns     = 20,
    parameter int    FilterPeriod_ns    = 1_000_000,
    parameter int    PauseInterval_ns   = 400_000_000,
    parameter int    RepeatsInterval_ns = 150_000_000,
    localparam int   ChBits             = (Channels > 1) ? $clog2(Channels) : 1
) (
    input  logic                     Clock,
    input  logic                     nReset,
    input  logic                     Button_Up,
    input  logic                     Button_Down,
    input  logic                     Button_Zero,
    input  logic                     Button_Sign,
    input  logic                     Button_Select,
    output logic [Channels*Size-1:0] Data,
    output logic [ChBits-1:0]        Channel
);

    localparam bit IsSigned     = (Signed == "Yes");
    localparam bit IsWrap       = (Wrap == "Yes");
    localparam int FilterCycles = ns_to_cycles(FilterPeriod_ns, ClockPeriod_ns);
    localparam int PauseCycles  = ns_to_cycles(PauseInterval_ns, ClockPeriod_ns);
    localparam int RepeatCycles = ns_to_cycles(RepeatsInterval_ns, ClockPeriod_ns);

    logic [NUM_BUTTONS-1:0] w_buttons;
    logic [NUM_BUTTONS-1:0] w_pulse;
    logic [NUM_BUTTONS-1:0] w_fast;

    logic [Channels-1:0][Size-1:0] r_data;
    logic [ChBits-1:0]             r_channel;

    logic [Size-1:0]          w_cur;
    logic                     w_fast_sel;
    logic signed [Size+1:0]   w_ext;
    logic signed [Size+1:0]   w_step;
    logic signed [Size+1:0]   w_sum;
    logic signed [Size+1:0]   w_neg;
    logic [Size-1:0]          w_sum_lim;
    logic [Size-1:0]          w_neg_lim;

    assign w_buttons = {Button_Select, Button_Sign, Button_Zero, Button_Down, Button_Up};

    for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_btn
        button_conditioner #(
            .Repeat       (gi == BTN_UP || gi == BTN_DOWN),
            .FilterCycles (FilterCycles),
            .PauseCycles  (PauseCycles),
            .RepeatCycles (RepeatCycles),
            .AccelAfter   (AccelAfter)
        ) u_cond (
            .Clock  (Clock),
            .nReset (nReset),
            .Button (w_buttons[gi]),
            .Pulse  (w_pulse[gi]),
            .Fast   (w_fast[gi])
        );
    end

    // Arithmetic runs two bits wider than the word so overflow is visible before limiting.
    always_comb begin
        w_cur      = r_data[r_channel];
        w_fast_sel = w_fast[w_pulse[BTN_DOWN] ? BTN_DOWN : BTN_UP];
        w_ext      = IsSigned ? {{2{w_cur[Size-1]}}, w_cur} : {2'b00, w_cur};
        w_step     = w_fast_sel ? (Size+2)'(FastStep) : (Size+2)'(1);
        w_sum      = w_pulse[BTN_UP] ? (w_ext + w_step) : (w_ext - w_step);
        w_neg      = -w_ext;
        w_sum_lim  = Size'(clamp_or_wrap(int'(w_sum), Size, IsSigned, IsWrap));
        w_neg_lim  = Size'(clamp_or_wrap(int'(w_neg), Size, IsSigned, IsWrap));
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_data    <= '0;
            r_channel <= '0;
        end else begin
            if (w_pulse[BTN_ZERO])
                r_data[r_channel] <= '0;
            else if (w_pulse[BTN_SIGN] && IsSigned)
                r_data[r_channel] <= w_neg_lim;
            else if (w_pulse[BTN_UP] != w_pulse[BTN_DOWN])
                r_data[r_channel] <= w_sum_lim;
            if (w_pulse[BTN_SELECT])
                r_channel <= (r_channel == ChBits'(Channels - 1)) ? '0 : r_channel + ChBits'(1);
        end
    end

    assign Data    = r_data;
    assign Channel = r_channel;

endmodule

// File: tb/tb_data_generator_mc.sv
// tb/tb_data_generator_mc.sv - directed bench for data_generator_mc in four arithmetic modes
module tb_data_generator_mc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        b_up = 1'b0, b_down = 1'b0, b_zero = 1'b0, b_sign = 1'b0, b_sel = 1'b0;
    logic [15:0] d_us, d_uw, d_ss, d_sw;
    logic [1:0]  c_us, c_uw, c_ss, c_sw;
    int          total = 0;
    int          bad = 0;

    localparam logic [4:0] M_UP   = 5'b00001;
    localparam logic [4:0] M_DN   = 5'b00010;
    localparam logic [4:0] M_ZERO = 5'b00100;
    localparam logic [4:0] M_SIGN = 5'b01000;
    localparam logic [4:0] M_SEL  = 5'b10000;

    always #10 clk = ~clk;

    data_generator_mc #(.Size(4), .Channels(4), .Signed("No"), .Wrap("No"), .FastStep(4),
        .AccelAfter(2), .ClockPeriod_ns(20), .FilterPeriod_ns(80), .PauseInterval_ns(400),
        .RepeatsInterval_ns(200)) u_us (
        .Clock(clk), .nReset(rst_n), .Button_Up(b_up), .Button_Down(b_down),
        .Button_Zero(b_zero), .Button_Sign(b_sign), .Button_Select(b_sel),
        .Data(d_us), .Channel(c_us));

    data_generator_mc #(.Size(4), .Channels(4), .Signed("No"), .Wrap("Yes"), .FastStep(4),
        .AccelAfter(2), .ClockPeriod_ns(20), .FilterPeriod_ns(80), .PauseInterval_ns(400),
        .RepeatsInterval_ns(200)) u_uw (
        .Clock(clk), .nReset(rst_n), .Button_Up(b_up), .Button_Down(b_down),
        .Button_Zero(b_zero), .Button_Sign(b_sign), .Button_Select(b_sel),
        .Data(d_uw), .Channel(c_uw));

    data_generator_mc #(.Size(4), .Channels(4), .Signed("Yes"), .Wrap("No"), .FastStep(4),
        .AccelAfter(2), .ClockPeriod_ns(20), .FilterPeriod_ns(80), .PauseInterval_ns(400),
        .RepeatsInterval_ns(200)) u_ss (
        .Clock(clk), .nReset(rst_n), .Button_Up(b_up), .Button_Down(b_down),
        .Button_Zero(b_zero), .Button_Sign(b_sign), .Button_Select(b_sel),
        .Data(d_ss), .Channel(c_ss));

    data_generator_mc #(.Size(4), .Channels(4), .Signed("Yes"), .Wrap("Yes"), .FastStep(4),
        .AccelAfter(2), .ClockPeriod_ns(20), .FilterPeriod_ns(80), .PauseInterval_ns(400),
        .RepeatsInterval_ns(200)) u_sw (
        .Clock(clk), .nReset(rst_n), .Button_Up(b_up), .Button_Down(b_down),
        .Button_Zero(b_zero), .Button_Sign(b_sign), .Button_Select(b_sel),
        .Data(d_sw), .Channel(c_sw));

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input logic [4:0] m);
        {b_sel, b_sign, b_zero, b_down, b_up} = m;
    endtask

    task automatic press(input logic [4:0] m);
        set_btn(m);
        tick(6);
        set_btn(5'b0);
        tick(10);
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick(2);
        total++;
        if ({d_us, d_uw, d_ss, d_sw} !== 64'h0) begin
            bad++;
            $display("FAIL reset_data: got %h expected 0", {d_us, d_uw, d_ss, d_sw});
        end
        total++;
        if ({c_us, c_uw, c_ss, c_sw} !== 8'h0) begin
            bad++;
            $display("FAIL reset_channel: got %h expected 0", {c_us, c_uw, c_ss, c_sw});
        end
        rst_n = 1'b1;
        tick(3);
        total++;
        if ({d_us, d_uw, d_ss, d_sw} !== 64'h0) begin
            bad++;
            $display("FAIL reset_release: got %h expected 0", {d_us, d_uw, d_ss, d_sw});
        end
    endtask

    task automatic test_press_latency;
        set_btn(M_UP);
        tick(5);
        set_btn(5'b0);
        tick(2);
        total++;
        if (d_us !== 16'h0000) begin
            bad++;
            $display("FAIL latency_early: got %h expected 0000 at cycle 7", d_us);
        end
        tick(1);
        total++;
        if ({d_us, d_uw, d_ss, d_sw} !== {4{16'h0001}}) begin
            bad++;
            $display("FAIL latency_cycle8: got %h expected %h", {d_us, d_uw, d_ss, d_sw}, {4{16'h0001}});
        end
        total++;
        if (c_us !== 2'd0) begin
            bad++;
            $display("FAIL latency_channel: got %0d expected 0", c_us);
        end
        tick(20);
        total++;
        if (d_us !== 16'h0001) begin
            bad++;
            $display("FAIL latency_no_repeat: got %h expected 0001", d_us);
        end
    endtask

    task automatic test_repeat_accel;
        int         exp_cyc[5] = '{8, 28, 38, 48, 58};
        logic [3:0] exp_val[5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd8};
        int         rec_cyc[8];
        logic [3:0] rec_val[8];
        int         nrec = 0;
        logic [3:0] prev;
        for (int i = 0; i < 8; i++) begin
            rec_cyc[i] = -1;
            rec_val[i] = 4'hx;
        end
        do_reset();
        prev = d_us[3:0];
        set_btn(M_UP);
        for (int c = 1; c <= 60; c++) begin
            tick(1);
            if (d_us[3:0] !== prev) begin
                if (nrec < 8) begin
                    rec_cyc[nrec] = c;
                    rec_val[nrec] = d_us[3:0];
                end
                nrec++;
                prev = d_us[3:0];
            end
        end
        set_btn(5'b0);
        tick(20);
        total++;
        if (nrec != 5) begin
            bad++;
            $display("FAIL repeat_count: got %0d steps expected 5", nrec);
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (rec_cyc[i] != exp_cyc[i] || rec_val[i] !== exp_val[i]) begin
                bad++;
                $display("FAIL repeat_step%0d: got value %0d at cycle %0d expected %0d at cycle %0d",
                         i, rec_val[i], rec_cyc[i], exp_val[i], exp_cyc[i]);
            end
        end
        total++;
        if (d_us !== 16'h0008) begin
            bad++;
            $display("FAIL repeat_after_release: got %h expected 0008", d_us);
        end
    endtask

    task automatic test_sat_wrap;
        logic [3:0] exp_sat[3]  = '{4'd15, 4'd15, 4'd15};
        logic [3:0] exp_wrap[3] = '{4'd15, 4'd0, 4'd1};
        for (int i = 0; i < 6; i++) press(M_UP);
        total++;
        if (d_us[3:0] !== 4'd14 || d_uw[3:0] !== 4'd14) begin
            bad++;
            $display("FAIL satwrap_start: got %0d/%0d expected 14/14", d_us[3:0], d_uw[3:0]);
        end
        for (int i = 0; i < 3; i++) begin
            press(M_UP);
            total++;
            if (d_us[3:0] !== exp_sat[i]) begin
                bad++;
                $display("FAIL saturate_up%0d: got %0d expected %0d", i, d_us[3:0], exp_sat[i]);
            end
            total++;
            if (d_uw[3:0] !== exp_wrap[i]) begin
                bad++;
                $display("FAIL wrap_up%0d: got %0d expected %0d", i, d_uw[3:0], exp_wrap[i]);
            end
        end
    endtask

    task automatic test_signed;
        do_reset();
        set_btn(M_DN);
        tick(60);
        set_btn(5'b0);
        tick(20);
        total++;
        if ({d_ss[3:0], d_sw[3:0], d_uw[3:0], d_us[3:0]} !== 16'h8880) begin
            bad++;
            $display("FAIL down_hold: got %h expected 8880", {d_ss[3:0], d_sw[3:0], d_uw[3:0], d_us[3:0]});
        end
        press(M_SIGN);
        total++;
        if (d_ss[3:0] !== 4'h7) begin
            bad++;
            $display("FAIL sign_saturate: got %h expected 7", d_ss[3:0]);
        end
        total++;
        if (d_sw[3:0] !== 4'h8) begin
            bad++;
            $display("FAIL sign_wrap: got %h expected 8", d_sw[3:0]);
        end
        total++;
        if (d_uw[3:0] !== 4'h8) begin
            bad++;
            $display("FAIL sign_unsigned_ignored: got %h expected 8", d_uw[3:0]);
        end
        press(M_UP | M_DN);
        total++;
        if (d_ss[3:0] !== 4'h7 || d_sw[3:0] !== 4'h8) begin
            bad++;
            $display("FAIL up_down_cancel: got %h/%h expected 7/8", d_ss[3:0], d_sw[3:0]);
        end
    endtask

    task automatic test_select;
        logic [1:0] exp_ch[5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        do_reset();
        press(M_UP);
        for (int i = 0; i < 5; i++) begin
            press(M_SEL);
            total++;
            if (c_us !== exp_ch[i]) begin
                bad++;
                $display("FAIL select%0d: got %0d expected %0d", i, c_us, exp_ch[i]);
            end
        end
        press(M_UP);
        press(M_UP);
        total++;
        if (d_us !== 16'h0021) begin
            bad++;
            $display("FAIL isolation: got %h expected 0021", d_us);
        end
        press(M_ZERO | M_UP);
        total++;
        if (d_us !== 16'h0001) begin
            bad++;
            $display("FAIL zero_priority: got %h expected 0001", d_us);
        end
        press(M_SEL | M_UP);
        total++;
        if (d_us !== 16'h0011 || c_us !== 2'd2) begin
            bad++;
            $display("FAIL select_with_up: got %h ch %0d expected 0011 ch 2", d_us, c_us);
        end
    endtask

    task automatic test_bounce_reset;
        do_reset();
        press(M_SEL);
        set_btn(M_UP); tick(3);
        set_btn(5'b0); tick(2);
        set_btn(M_UP); tick(3);
        set_btn(5'b0); tick(20);
        total++;
        if (d_us !== 16'h0000) begin
            bad++;
            $display("FAIL bounce: got %h expected 0000", d_us);
        end
        set_btn(M_UP);
        tick(40);
        total++;
        if (d_us !== 16'h0030 || c_us !== 2'd1) begin
            bad++;
            $display("FAIL hold_before_reset: got %h ch %0d expected 0030 ch 1", d_us, c_us);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({d_us, d_sw} !== 32'h0 || c_us !== 2'd0) begin
            bad++;
            $display("FAIL async_reset: got %h ch %0d expected 0 ch 0", {d_us, d_sw}, c_us);
        end
        tick(2);
        rst_n = 1'b1;
        tick(7);
        total++;
        if (d_us !== 16'h0000) begin
            bad++;
            $display("FAIL post_reset_early: got %h expected 0000", d_us);
        end
        tick(1);
        total++;
        if (d_us !== 16'h0001) begin
            bad++;
            $display("FAIL post_reset_step: got %h expected 0001", d_us);
        end
        tick(15);
        total++;
        if (d_us !== 16'h0001) begin
            bad++;
            $display("FAIL post_reset_single: got %h expected 0001", d_us);
        end
        set_btn(5'b0);
        tick(20);
    endtask

    initial begin
        test_reset();
        test_press_latency();
        test_repeat_accel();
        test_sat_wrap();
        test_signed();
        test_select();
        test_bounce_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_generator_mc.md
# data_generator_mc

Multi-channel successor to the single-channel push-button data generator. It debounces five panel buttons and turns Up/Down holds into single steps followed by auto-repeat, with acceleration. It keeps `Channels` independent `Size`-bit values, each settable by the user. It sits between the board buttons and the display/DAC consumers, one word per channel.

## Interface
Parameters:
- `Size`, 4: width of each channel word.
- `Channels`, 4: number of independent channels (≥2).
- `Signed`, "No": "Yes" gives two's-complement words and enables Sign.
- `Wrap`, "No": "Yes" gives modular overflow; "No" saturates at the limits.
- `FastStep`, 4: step magnitude after acceleration.
- `AccelAfter`, 8: number of repeat pulses before the step switches to `FastStep`.
- `ClockPeriod_ns`, 20: clock period.
- `FilterPeriod_ns`, 1_000_000: debounce stable time.
- `PauseInterval_ns`, 400_000_000: hold time before the first repeat.
- `RepeatsInterval_ns`, 150_000_000: repeat period.

Ports:
- `Clock`, in, 1: single clock. All state is clocked on its rising edge.
- `nReset`, in, 1: reset, asynchronous and active-low.
- `Button_Up`, `Button_Down`, `Button_Zero`, `Button_Sign`, `Button_Select`, in, 1 each: raw active-high buttons, asynchronous to `Clock`.
- `Data`, out, `Channels*Size`: channel k occupies bits `[k*Size +: Size]`.
- `Channel`, out, `ChBits` = max(1, $clog2(Channels)): index of the active channel.

## Operation
- **Reset**: while `nReset`=0, all `Data` words are 0, `Channel`=0, and all filter, repeat and acceleration state is cleared. There is no output glitch on release.
- **Input synchronisation**: each button passes through a 2-flop synchroniser.
- **Debounce**: the filtered level toggles only after the synchronised input has differed from it for `FilterCycles` = FilterPeriod_ns/ClockPeriod_ns consecutive cycles.
- **Repeat generator (Up and Down only)**: runs IDLE → FIRST → PAUSE → REPEAT.
  - Rising filtered edge: one step pulse, then PAUSE.
  - PAUSE: after `PauseCycles` held, one pulse, then REPEAT.
  - REPEAT: one pulse every `RepeatCycles` while held.
  - Release from any state returns to IDLE.
- **Acceleration**: step magnitude is 1 until `AccelAfter` REPEAT pulses have occurred in the current hold, then `FastStep`. The count clears on release.
- **Zero, Sign, Select**: each acts once per filtered rising edge and never repeats.
- **Select**: `Channel` advances by 1 and wraps from Channels-1 to 0. A release-and-repress of Up/Down on the new channel starts a fresh hold, so acceleration does not carry over.
- **Arithmetic**: computed in `Size+2` bits, then limited to the range below.
  - Range is [0, 2^Size−1] when unsigned, [−2^(Size−1), 2^(Size−1)−1] when signed.
  - Saturate mode clamps to the nearest limit.
  - Wrap mode keeps the low `Size` bits.
- **Sign**:
  - Signed mode: negates the active word. Negating the most-negative value gives max in saturate mode and leaves the value unchanged in wrap mode.
  - Unsigned mode: Sign is ignored.
- **Priority within one cycle**: Zero > Sign > Up/Down.
  - Up and Down pulses in the same cycle cancel; no change.
  - A Select edge in the same cycle as an action applies that action to the old channel, then advances.
- Only the active channel ever changes. Other words hold their values.

## Timing
- **Press latency**: a clean press held from sample cycle 0 changes `Data` at cycle `FilterCycles`+4 (2 sync + filter + pulse register + data register).
- **First repeat**: `PauseCycles` after the first step.
- **Subsequent repeats**: every `RepeatCycles`.
- **Channel update**: `Channel` updates with the same latency as `Data`.
- **Outputs**: `Data` and `Channel` come straight from registers; there are no combinational paths from input to output.
- **Async reset mid-hold**: outputs return to their reset values immediately. After release, a still-held button needs a fresh filtered edge, which appears `FilterCycles`+2 cycles after the sampled level.

## Structure
- **Package `data_generator_pkg`**:
  - repeat-state enum (IDLE, FIRST, PAUSE, REPEAT);
  - function `ns_to_cycles(ns, period)`;
  - function `clamp_or_wrap(value, size, signed, wrap)`.
- **Sub-module `button_conditioner`**:
  - parameters: `Repeat` on/off, cycle counts;
  - contents: synchroniser, debounce and repeat FSM;
  - outputs: `Pulse` and `Fast` (acceleration reached).
  - Five instances: Up and Down with repeat, Zero, Sign and Select without.
- **Top level**: channel register file, active-channel counter and arithmetic.

## Test plan
Bench parameters: Size=4, Channels=4, FilterCycles=4, PauseCycles=20, RepeatCycles=10, AccelAfter=2, FastStep=4.

- **Press latency**: reset, then Up pressed cleanly for 1 cycle beyond filter → channel 0 = 1 at cycle 8; Data = 16'h0001; Channel = 0.
- **Repeat and acceleration**: Up held for 60 cycles → channel 0 values 1, 2, 3, 4, then 8 at repeat pulses 3+; pulses 20 and 10 cycles apart.
- **Unsigned saturate vs wrap**: channel at 14, Up×3 → saturate: 15, 15, 15; with Wrap="Yes": 15, 0, 1.
- **Signed mode**: value −8, Sign → 7 in saturate mode, −8 in wrap mode; Up and Down simultaneous → no change.
- **Select and isolation**: Select×5 → Channel sequence 1, 2, 3, 0, 1; Up on channel 1 leaves channels 0, 2 and 3 unchanged; Zero in the same cycle as Up → 0.
- **Bounce and reset**: bounces shorter than 4 cycles → no change; `nReset` low during REPEAT → all outputs 0 immediately; Up still held after release → exactly one step after the filter delay.
